// File: rtl/ahb_spi_flash_xip.sv
// ============================================================================
// ahb_spi_flash_xip
// ----------------------------------------------------------------------------
// Execute-in-place bridge: serves AHB-Lite reads from a serial NOR flash by
// issuing READ (0x03) commands over a mode-0 SPI link. Chip select is held low
// after a read so that the next word-sequential read can stream straight out
// of the flash without a new command. Writes are answered with an AHB ERROR.
//
// Ports
//   clk, rst_n           system clock (rising edge) / asynchronous active-low reset
//   ahbls_*              AHB-Lite slave; hready_resp/hresp/hrdata are outputs,
//                        hburst/hprot/hmastlock/hwdata/hsize are not used
//   spi_cs_n, spi_sck,   SPI master outputs (mode 0, one bit = 2 clk)
//   spi_mosi
//   spi_miso             SPI data from the flash
// ============================================================================
module ahb_spi_flash_xip #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ahbls_hready_resp,
    input  logic              ahbls_hready,
    output logic              ahbls_hresp,
    input  logic [W_ADDR-1:0] ahbls_haddr,
    input  logic              ahbls_hwrite,
    input  logic [1:0]        ahbls_htrans,
    input  logic [2:0]        ahbls_hsize,
    input  logic [2:0]        ahbls_hburst,
    input  logic [3:0]        ahbls_hprot,
    input  logic              ahbls_hmastlock,
    input  logic [W_DATA-1:0] ahbls_hwdata,
    output logic [W_DATA-1:0] ahbls_hrdata,
    output logic              spi_cs_n,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    typedef enum logic [2:0] {
        IDLE,
        DESELECT,
        SELECT,
        CMD,
        DATA,
        DONE,
        ERR0,
        ERR1
    } state_t;

    state_t      state_reg;
    logic [5:0]  cnt_reg;          // clk count within CMD / DATA (2 per bit)
    logic [31:0] tx_reg;           // command + address, shifted out MSB first
    logic [31:0] rx_reg;           // received bits, first bit ends up at [31]
    logic [21:0] req_addr_reg;     // word address of the read in progress
    logic [21:0] stream_addr_reg;  // word address of the last completed read
    logic        stream_valid_reg;

    logic        accept;
    logic [21:0] addr_word;
    logic        seq_hit;
    logic [31:0] rx_final;
    logic [31:0] rx_swapped;

    assign accept    = ahbls_hready & ahbls_htrans[1];
    assign addr_word = ahbls_haddr[23:2];
    // Natural 22-bit wrap makes 0xFFFFFC -> 0x000000 count as sequential.
    assign seq_hit   = stream_valid_reg && (addr_word == stream_addr_reg + 22'd1);
    // The last bit is sampled on the same edge that moves DATA -> DONE.
    assign rx_final  = {rx_reg[30:0], spi_miso};

    // First byte received goes to the least significant lane.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_lane
            assign rx_swapped[8*gi +: 8] = rx_final[8*(3-gi) +: 8];
        end
    endgenerate

    logic unused_inputs;
    assign unused_inputs = ^{ahbls_haddr[W_ADDR-1:24], ahbls_haddr[1:0], ahbls_htrans[0],
                             ahbls_hsize, ahbls_hburst, ahbls_hprot, ahbls_hmastlock,
                             ahbls_hwdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            cnt_reg           <= 6'd0;
            tx_reg            <= 32'd0;
            rx_reg            <= 32'd0;
            req_addr_reg      <= 22'd0;
            stream_addr_reg   <= 22'd0;
            stream_valid_reg  <= 1'b0;
            spi_cs_n          <= 1'b1;
            spi_sck           <= 1'b0;
            spi_mosi          <= 1'b0;
            ahbls_hready_resp <= 1'b1;
            ahbls_hresp       <= 1'b0;
            ahbls_hrdata      <= '0;
        end else begin
            case (state_reg)
                // States in which the bus sees hready high and may start a new
                // transfer; the response to it begins on the very next cycle.
                IDLE, DONE, ERR1: begin
                    if (accept && ahbls_hwrite) begin
                        state_reg         <= ERR0;
                        ahbls_hready_resp <= 1'b0;
                        ahbls_hresp       <= 1'b1;
                        spi_cs_n          <= 1'b1;
                        stream_valid_reg  <= 1'b0;
                    end else if (accept) begin
                        req_addr_reg      <= addr_word;
                        ahbls_hready_resp <= 1'b0;
                        ahbls_hresp       <= 1'b0;
                        cnt_reg           <= 6'd0;
                        if (!spi_cs_n && seq_hit) begin
                            // Flash is still streaming the next word.
                            state_reg <= DATA;
                        end else if (!spi_cs_n) begin
                            state_reg <= DESELECT;
                            spi_cs_n  <= 1'b1;
                        end else begin
                            state_reg <= SELECT;
                            spi_cs_n  <= 1'b0;
                        end
                    end else begin
                        state_reg         <= IDLE;
                        ahbls_hready_resp <= 1'b1;
                        ahbls_hresp       <= 1'b0;
                    end
                end
                DESELECT: begin
                    state_reg <= SELECT;
                    spi_cs_n  <= 1'b0;
                end
                SELECT: begin
                    state_reg <= CMD;
                    cnt_reg   <= 6'd0;
                    tx_reg    <= {8'h03, req_addr_reg, 2'b00};
                    spi_mosi  <= 1'b0;  // MSB of 0x03
                end
                CMD: begin
                    cnt_reg <= cnt_reg + 6'd1;
                    if (!cnt_reg[0]) begin
                        spi_sck <= 1'b1;
                    end else begin
                        spi_sck <= 1'b0;
                        if (cnt_reg == 6'd63) begin
                            state_reg <= DATA;
                            spi_mosi  <= 1'b0;
                        end else begin
                            spi_mosi <= tx_reg[30];
                            tx_reg   <= {tx_reg[30:0], 1'b0};
                        end
                    end
                end
                DATA: begin
                    cnt_reg <= cnt_reg + 6'd1;
                    if (!cnt_reg[0]) begin
                        spi_sck <= 1'b1;
                    end else begin
                        spi_sck <= 1'b0;
                        rx_reg  <= rx_final;
                        if (cnt_reg == 6'd63) begin
                            state_reg         <= DONE;
                            ahbls_hrdata      <= rx_swapped;
                            ahbls_hready_resp <= 1'b1;
                            stream_addr_reg   <= req_addr_reg;
                            stream_valid_reg  <= 1'b1;
                        end
                    end
                end
                ERR0: begin
                    state_reg         <= ERR1;
                    ahbls_hready_resp <= 1'b1;
                end
                default: begin
                    state_reg         <= IDLE;
                    ahbls_hready_resp <= 1'b1;
                    ahbls_hresp       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_spi_flash_xip.sv
// ============================================================================
// tb_ahb_spi_flash_xip
// ----------------------------------------------------------------------------
// Directed + randomized bench for ahb_spi_flash_xip. A behavioural SPI flash
// (byte table, READ command decode, continuous streaming) sits on the SPI
// pins; expected wait states, chip-select behaviour, sck edge counts, command
// words and read data come from a transaction-level model of the bridge.
// ============================================================================
module tb_ahb_spi_flash_xip;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hready_resp;
    logic        hresp;
    logic [31:0] haddr = 32'd0;
    logic        hwrite = 1'b0;
    logic [1:0]  htrans = 2'b00;
    logic [2:0]  hsize = 3'b010;
    logic [2:0]  hburst = 3'b000;
    logic [3:0]  hprot = 4'b0011;
    logic        hmastlock = 1'b0;
    logic [31:0] hwdata = 32'd0;
    logic [31:0] hrdata;
    logic        spi_cs_n;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    ahb_spi_flash_xip #(.W_ADDR(32), .W_DATA(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ahbls_hready_resp (hready_resp),
        .ahbls_hready      (hready_resp),
        .ahbls_hresp       (hresp),
        .ahbls_haddr       (haddr),
        .ahbls_hwrite      (hwrite),
        .ahbls_htrans      (htrans),
        .ahbls_hsize       (hsize),
        .ahbls_hburst      (hburst),
        .ahbls_hprot       (hprot),
        .ahbls_hmastlock   (hmastlock),
        .ahbls_hwdata      (hwdata),
        .ahbls_hrdata      (hrdata),
        .spi_cs_n          (spi_cs_n),
        .spi_sck           (spi_sck),
        .spi_mosi          (spi_mosi),
        .spi_miso          (spi_miso)
    );

    // ---------------- flash contents and behavioural flash ----------------
    logic [7:0]  mem [0:4095];
    int          sck_rises = 0;
    int          cmd_count = 0;
    logic [31:0] last_cmd = 32'd0;

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        return mem[a[11:0]];
    endfunction

    always @(posedge spi_sck) sck_rises++;

    initial begin : flash_model
        logic [31:0] sh;
        logic [23:0] fa;
        logic [7:0]  cur;
        bit          abort;
        spi_miso = 1'b0;
        forever begin
            @(negedge spi_cs_n);
            abort = 0;
            sh = 32'd0;
            for (int i = 0; i < 32; i++) begin
                @(posedge spi_sck or posedge spi_cs_n);
                if (spi_cs_n) begin
                    abort = 1;
                    break;
                end
                sh = {sh[30:0], spi_mosi};
            end
            if (!abort) begin
                last_cmd = sh;
                cmd_count++;
                fa = sh[23:0];
                while (!abort) begin
                    cur = fbyte(fa);
                    fa = fa + 24'd1;
                    for (int b = 7; b >= 0; b--) begin
                        @(negedge spi_sck or posedge spi_cs_n);
                        if (spi_cs_n) begin
                            abort = 1;
                            break;
                        end
                        #1 spi_miso = cur[b];
                    end
                end
            end
        end
    end

    // ---------------- bridge reference model ----------------
    bit          m_sel = 0;       // chip select held low
    logic [21:0] m_stream = 22'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One complete AHB transfer starting at a negedge with hready high; returns
    // at the negedge of the completing cycle (next address may be driven then).
    task automatic xfer(input bit wr, input logic [31:0] addr);
        logic [21:0] word;
        logic [23:0] ba;
        logic [31:0] exp_data;
        logic [31:0] hr_before;
        int          exp_waits, exp_cshi, exp_rises, exp_cmds;
        int          waits, cshi, rises0, cmds0;
        bit          seq, hr_changed, hresp_bad;
        string       kind;

        word = addr[23:2];
        ba   = {word, 2'b00};
        seq  = m_sel && (word == m_stream + 22'd1);
        exp_data = {fbyte(ba + 24'd3), fbyte(ba + 24'd2), fbyte(ba + 24'd1), fbyte(ba)};
        if (wr) begin
            kind = "write"; exp_waits = 1; exp_cshi = 2; exp_rises = 0; exp_cmds = 0;
        end else if (seq) begin
            kind = "seq"; exp_waits = 64; exp_cshi = 0; exp_rises = 32; exp_cmds = 0;
        end else if (m_sel) begin
            kind = "nonseq"; exp_waits = 130; exp_cshi = 1; exp_rises = 64; exp_cmds = 1;
        end else begin
            kind = "cold"; exp_waits = 129; exp_cshi = 0; exp_rises = 64; exp_cmds = 1;
        end

        rises0 = sck_rises;
        cmds0 = cmd_count;
        hr_before = hrdata;
        htrans = 2'b10;
        hwrite = wr;
        haddr = addr;
        hsize = 3'($urandom_range(0, 2));
        hburst = 3'($urandom);
        hprot = 4'($urandom);
        hmastlock = 1'($urandom);
        hwdata = $urandom;
        @(posedge clk);
        #1;
        htrans = 2'b00;
        hwrite = 1'b0;
        haddr = $urandom;
        waits = 0;
        cshi = 0;
        hr_changed = 0;
        hresp_bad = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (spi_cs_n) cshi++;
            if (hready_resp) break;
            waits++;
            if (hrdata !== hr_before) hr_changed = 1;
            if (hresp !== wr) hresp_bad = 1;
        end
        chk({kind, "_timeout"}, hready_resp, 1'b1);
        chk({kind, "_waits"}, waits, exp_waits);
        chk({kind, "_resp_final"}, hresp, wr);
        chk({kind, "_resp_wait"}, hresp_bad, 1'b0);
        chk({kind, "_cs_high_cycles"}, cshi, exp_cshi);
        chk({kind, "_sck_rises"}, sck_rises - rises0, exp_rises);
        chk({kind, "_hrdata_hold"}, hr_changed, 1'b0);
        chk({kind, "_sck_idle"}, spi_sck, 1'b0);
        chk({kind, "_mosi_idle"}, spi_mosi, 1'b0);
        chk({kind, "_cmd_count"}, cmd_count - cmds0, exp_cmds);
        if (wr) begin
            chk("write_hrdata_kept", hrdata, hr_before);
            chk("write_cs_high", spi_cs_n, 1'b1);
            m_sel = 0;
        end else begin
            chk({kind, "_hrdata"}, hrdata, exp_data);
            chk({kind, "_cs_low"}, spi_cs_n, 1'b0);
            if (!seq) chk({kind, "_cmd_word"}, last_cmd, {8'h03, ba});
            m_sel = 1;
            m_stream = word;
        end
        $display("xfer %-6s addr=%08h waits=%0d hresp=%0b hrdata=%08h", kind, addr, waits, hresp,
                 hrdata);
    endtask

    task automatic idle_cycles(input int n);
        htrans = 2'b00;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[12'h010] = 8'h11;
        mem[12'h011] = 8'h22;
        mem[12'h012] = 8'h33;
        mem[12'h013] = 8'h44;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_cs_n", spi_cs_n, 1'b1);
        chk("rst_sck", spi_sck, 1'b0);
        chk("rst_mosi", spi_mosi, 1'b0);
        chk("rst_hready", hready_resp, 1'b1);
        chk("rst_hresp", hresp, 1'b0);
        chk("rst_hrdata", hrdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // cold, sequential, hold, non-sequential
        xfer(0, 32'h0000_0010);
        chk("first_word", hrdata, 32'h4433_2211);
        xfer(0, 32'h0000_0014);
        idle_cycles(3);
        chk("hrdata_hold_idle", hrdata, {fbyte(24'h17), fbyte(24'h16), fbyte(24'h15), fbyte(24'h14)});
        chk("cs_low_idle", spi_cs_n, 1'b0);
        xfer(0, 32'h0000_0040);

        // IDLE and BUSY get zero-wait OKAY and leave the stream alone
        htrans = 2'b01;
        @(posedge clk);
        #1;
        htrans = 2'b00;
        @(negedge clk);
        chk("busy_hready", hready_resp, 1'b1);
        chk("busy_hresp", hresp, 1'b0);
        chk("busy_cs_low", spi_cs_n, 1'b0);
        @(negedge clk);
        chk("idle_hready", hready_resp, 1'b1);
        xfer(0, 32'h0000_0044);

        // write error, then cold read
        xfer(1, 32'h0000_0000);
        idle_cycles(1);
        xfer(0, 32'h0000_0020);

        // wrap of the 24-bit window, then back-to-back sequential reads
        xfer(0, 32'h00FF_FFFC);
        xfer(0, 32'h0100_0000);
        xfer(0, 32'h0100_0004);
        xfer(0, 32'h0100_0008);
        xfer(0, 32'hAB00_000F);

        // randomized mix
        for (int n = 0; n < 16; n++) begin
            int r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                xfer(1, $urandom);
            end else if (r < 6) begin
                a = {8'($urandom), m_stream + 22'd1, 2'($urandom)};
                xfer(0, a);
            end else begin
                xfer(0, $urandom);
            end
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
        end

        // asynchronous reset during the command phase
        idle_cycles(1);
        htrans = 2'b10;
        hwrite = 1'b0;
        haddr = 32'h0000_0100;
        @(posedge clk);
        #1;
        htrans = 2'b00;
        repeat (20) @(negedge clk);
        chk("midcmd_cs_low", spi_cs_n, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_cs_n", spi_cs_n, 1'b1);
        chk("async_rst_sck", spi_sck, 1'b0);
        chk("async_rst_hready", hready_resp, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        m_sel = 0;
        @(negedge clk);
        xfer(0, 32'h0000_0104);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
